// File: rtl/column_fill_unit.sv
// column_fill_unit
//   Converts a stream of renderer column samples into vertical framebuffer
//   spans. A per-column y-buffer keeps the topmost row drawn so far. A new
//   sample that reaches higher than that row paints the gap down to the
//   previous top. At frame end a sky pass fills the rest of each column,
//   clears the y-buffer and waits for vsync. It then flips the back buffer
//   and acknowledges the renderer.
//
//   Build option: define COLUMN_FILL_SKY_EN to paint the sky during the
//   end-of-frame pass. Without it the pass only re-arms the y-buffer and
//   issues no framebuffer writes.
//
// Ports
//   Clk, Reset          clock (posedge), synchronous active-high reset
//   in_we/in_x/in_y/    renderer sample (held by upstream while stall=1)
//   in_color
//   in_done             renderer frame complete (held while stall=1)
//   vsync               display vertical-blank pulse
//   stall               1 whenever the unit is not accepting input
//   render_ack          one-cycle pulse starting the next renderer frame
//   fb_we/fb_x/fb_y/    registered framebuffer write port, one pixel/cycle
//   fb_color
//   fb_sel              back buffer being drawn (display reads ~fb_sel)
module column_fill_unit #(
  parameter logic [2:0] SKY_COLOR = 3'b011,
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_we,
  input  logic [8:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_color,
  input  logic       in_done,
  input  logic       vsync,
  output logic       stall,
  output logic       render_ack,
  output logic       fb_we,
  output logic [8:0] fb_x,
  output logic [7:0] fb_y,
  output logic [2:0] fb_color,
  output logic       fb_sel
);

  localparam logic [8:0] LAST_COL = 9'(SCREEN_W - 1);
  localparam logic [7:0] ROWS     = 8'(SCREEN_H);

  typedef enum logic [2:0] {
    INIT, ACCEPT, LOOKUP, FILL, SKY_RD, SKY_FILL, WAIT_VSYNC, ACK
  } state_t;

  state_t state, state_d;

  logic [7:0] ybuf [SCREEN_W];
  logic [7:0] ybuf_rd_p1;
  logic [8:0] rd_addr, wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;

  logic [8:0] col, col_d;
  logic [8:0] smp_x;
  logic [7:0] smp_y;
  logic [2:0] smp_color;
  logic       smp_ld;
  logic [7:0] end_row, end_row_d;

  logic       fb_we_d;
  logic [8:0] fb_x_d;
  logic [7:0] fb_y_d;
  logic [2:0] fb_color_d;
  logic       fb_sel_d;
  logic       sky_wr;

`ifdef COLUMN_FILL_SKY_EN
  assign sky_wr = 1'b1;
`else
  assign sky_wr = 1'b0;
`endif

  assign stall      = (state != ACCEPT);
  assign render_ack = (state == ACK);

  // The fb_* registers are loaded from the next-state decision, so fb_we is
  // high exactly while the FSM sits in FILL / SKY_FILL. fb_y doubles as the
  // row counter of the span being painted.
  always_comb begin
    state_d    = state;
    col_d      = col;
    end_row_d  = end_row;
    fb_we_d    = 1'b0;
    fb_x_d     = fb_x;
    fb_y_d     = fb_y;
    fb_color_d = fb_color;
    fb_sel_d   = fb_sel;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = col;
    wr_data    = ROWS;
    smp_ld     = 1'b0;
    case (state)
      INIT: begin
        wr_en = 1'b1;
        if (col == LAST_COL) begin
          col_d   = '0;
          state_d = ACK;
        end else begin
          col_d = col + 9'd1;
        end
      end
      ACCEPT: begin
        // Frame end wins; a sample held alongside it waits for the next frame.
        if (in_done) begin
          col_d   = '0;
          rd_addr = '0;
          state_d = SKY_RD;
        end else if (in_we) begin
          smp_ld  = 1'b1;
          rd_addr = in_x;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = ACCEPT;
        if (smp_x <= LAST_COL && smp_y < ROWS && smp_y < ybuf_rd_p1) begin
          wr_en      = 1'b1;
          wr_addr    = smp_x;
          wr_data    = smp_y;
          end_row_d  = ybuf_rd_p1 - 8'd1;
          fb_we_d    = 1'b1;
          fb_x_d     = smp_x;
          fb_y_d     = smp_y;
          fb_color_d = smp_color;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (fb_y == end_row) begin
          state_d = ACCEPT;
        end else begin
          fb_we_d = 1'b1;
          fb_y_d  = fb_y + 8'd1;
        end
      end
      SKY_RD: begin
        // ybuf_rd_p1 holds ybuf[col]; the entry is re-armed immediately since
        // its old value is captured in end_row for the span below.
        wr_en      = 1'b1;
        fb_color_d = SKY_COLOR;
        if (sky_wr && ybuf_rd_p1 != 8'd0) begin
          end_row_d = ybuf_rd_p1 - 8'd1;
          fb_we_d   = 1'b1;
          fb_x_d    = col;
          fb_y_d    = 8'd0;
          state_d   = SKY_FILL;
        end else if (col == LAST_COL) begin
          state_d = WAIT_VSYNC;
        end else begin
          col_d   = col + 9'd1;
          rd_addr = col + 9'd1;
        end
      end
      SKY_FILL: begin
        if (fb_y == end_row) begin
          if (col == LAST_COL) begin
            state_d = WAIT_VSYNC;
          end else begin
            col_d   = col + 9'd1;
            rd_addr = col + 9'd1;
            state_d = SKY_RD;
          end
        end else begin
          fb_we_d = 1'b1;
          fb_y_d  = fb_y + 8'd1;
        end
      end
      WAIT_VSYNC: begin
        if (vsync) begin
          fb_sel_d = ~fb_sel;
          state_d  = ACK;
        end
      end
      ACK: state_d = ACCEPT;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= INIT;
      col      <= '0;
      fb_we    <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
      fb_sel   <= 1'b0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      fb_we    <= fb_we_d;
      fb_x     <= fb_x_d;
      fb_y     <= fb_y_d;
      fb_color <= fb_color_d;
      fb_sel   <= fb_sel_d;
    end
  end

  always_ff @(posedge Clk) begin
    end_row <= end_row_d;
    if (smp_ld) begin
      smp_x     <= in_x;
      smp_y     <= in_y;
      smp_color <= in_color;
    end
  end

  // y-buffer: one write port, one registered read port
  always_ff @(posedge Clk) begin
    if (wr_en) ybuf[wr_addr] <= wr_data;
    ybuf_rd_p1 <= ybuf[rd_addr];
  end

endmodule

// File: doc/column_fill_unit.md
COLUMN_FILL_UNIT -- requirements
Module: column_fill_unit

Interface
REQ-001 SHALL have parameter SKY_COLOR, default 3'b011, colour used for the sky fill pass.
REQ-002 SHALL have parameter SCREEN_W, default 320, number of screen columns.
REQ-003 SHALL have parameter SCREEN_H, default 240, number of screen rows and the reset value of every y-buffer entry.
REQ-004 Clk  input  1  clock; all logic on posedge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 in_we  input  1  renderer sample valid; held with its data by upstream while stall=1.
REQ-007 in_x  input  9  sample column, 0..319.
REQ-008 in_y  input  8  sample top row, 0 = screen top.
REQ-009 in_color  input  3  sample colour.
REQ-010 in_done  input  1  renderer frame-complete; held by upstream while stall=1.
REQ-011 vsync  input  1  one-cycle pulse at display vertical blank.
REQ-012 stall  output  1  combinational; 1 whenever state != ACCEPT.
REQ-013 render_ack  output  1  one-cycle pulse that starts the next renderer frame.
REQ-014 fb_we, fb_x[8:0], fb_y[7:0], fb_color[2:0]  output  framebuffer write port; registered, one pixel per cycle.
REQ-015 fb_sel  output  1  back buffer currently being drawn; the display reads ~fb_sel.

Function
REQ-016 SHALL keep an internal y-buffer of SCREEN_W x 8-bit entries with 1-cycle read latency, holding the minimum row drawn so far per column.
REQ-017 States SHALL be INIT, ACCEPT, LOOKUP, FILL, SKY_RD, SKY_FILL, WAIT_VSYNC, ACK.
REQ-018 ACCEPT: if in_done=1, go to SKY_RD with column counter 0; else if in_we=1, latch x/y/color, issue y-buffer read of in_x, go to LOOKUP.
REQ-019 in_done SHALL take priority over in_we in the same cycle; the held in_we sample is accepted on the next ACCEPT.
REQ-020 LOOKUP: if latched y < 240 and y < ybuf[x], write ybuf[x] = y and go to FILL with row = y and end = ybuf[x]-1; otherwise discard the sample and return to ACCEPT.
REQ-021 FILL: drive fb_we=1, fb_x=x, fb_y=row, fb_color=color each cycle and increment row; after the cycle with row == end, return to ACCEPT.
REQ-022 Each accepted sample SHALL produce exactly (ybuf_old - y) pixel writes, or 0 if discarded.
REQ-023 SKY_RD/SKY_FILL SHALL visit every column 0..319 in order: read ybuf[x], write SKY_COLOR at rows 0..ybuf[x]-1 (none if ybuf[x]=0), then set ybuf[x]=240.
REQ-024 After column 319, the unit SHALL enter WAIT_VSYNC.
REQ-025 WAIT_VSYNC: on vsync=1, toggle fb_sel and go to ACK; vsync in any other state SHALL be ignored.
REQ-026 ACK: pulse render_ack=1 for exactly one cycle, then go to ACCEPT.
REQ-027 fb_we SHALL be 0 in every state other than FILL and SKY_FILL.

Reset
REQ-028 On Reset, outputs SHALL be: fb_we=0, render_ack=0, fb_sel=0, fb_x=0, fb_y=0, fb_color=0; state SHALL become INIT.
REQ-029 INIT SHALL write 240 to all 320 y-buffer entries over 320 cycles, then go to ACK.
REQ-030 Reset asserted mid-fill SHALL abort the fill, with no further fb_we after the reset cycle.

Configuration
REQ-031 Macro COLUMN_FILL_SKY_EN defined: the sky pass behaves per REQ-023.
REQ-032 Macro COLUMN_FILL_SKY_EN undefined: the sky pass still resets all entries to 240 over 320 cycles but issues no framebuffer writes (fb_we stays 0).

Verification
REQ-033 Reset, then observe: stall=1 for 320 INIT cycles, then one render_ack pulse, then stall=0.
REQ-034 Sample (x=5,y=200,c=2) into a fresh frame -> 40 writes at x=5, rows 200..239, colour 2; ybuf[5]=200.
REQ-035 Then sample (x=5,y=210,c=4) -> no writes. Then sample (x=5,y=190,c=1) -> 10 writes, rows 190..199, colour 1.
REQ-036 Sample with y=250 -> discarded, 0 writes.
REQ-037 Samples presented during FILL -> stall=1 and the held sample is accepted exactly once after the fill.
REQ-038 in_done after REQ-034/035 with COLUMN_FILL_SKY_EN defined -> column 5 gets rows 0..189 in SKY_COLOR, other columns get rows 0..239. Then vsync -> fb_sel toggles and one render_ack pulse. Without the macro -> 0 sky writes.
